// File: rtl/transmission_pkg.sv
// Shared definitions for the 8-way transmission path scheduler.
package transmission_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GUARD
  } stateT;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... with wrap.
module rr_pick8
  import transmission_pkg::*;
(
  input  logic [NCH-1:0]   iReq,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (iReq[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/transmission_arb8.sv
// Round-robin time-division scheduler for the 8:1 / 1:8 transmission line.
// Optional feature macro: TRANSMISSION_ARB_GUARD_EN inserts one dead cycle
// (GUARD) after every grant so the de-selector settles before a new owner.
//
// state | meaning
// IDLE  | no owner; pick from ptr when any request is present
// GRANT | channel sel owns the line; cnt counts cycles in the slot
// GUARD | dead cycle after a grant (guard build only), then acts as IDLE
module transmission_arb8
  import transmission_pkg::*;
#(
  parameter int SLOT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       iReq,
  output logic             oA,
  output logic             oB,
  output logic             oC,
  output logic [7:0]       oGrant,
  output logic             oValid,
  output logic [CNT_W-1:0] oSlotCnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

  stateT            state, stateNext;
  logic [SEL_W-1:0] sel, selNext;
  logic [SEL_W-1:0] ptr, ptrNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [NCH-1:0]   grant, grantNext;
  logic             valid, validNext;
  logic             endGrant;
  logic [SEL_W-1:0] pickPtr;
  logic [SEL_W-1:0] pickIdx;
  logic             pickFound;

  // At end of grant the re-pick must start after the current owner, one edge
  // before ptr itself is updated, so the picker sees sel+1 directly.
  assign pickPtr = (state == GRANT) ? sel + 3'd1 : ptr;

  rr_pick8 uPick (
    .iReq  (iReq),
    .ptr   (pickPtr),
    .idx   (pickIdx),
    .found (pickFound)
  );

  // Next-state and next-output decode.
  always_comb begin
    stateNext = state;
    selNext   = sel;
    ptrNext   = ptr;
    cntNext   = cnt;
    grantNext = grant;
    validNext = valid;
    endGrant  = 1'b0;
    case (state)
      GRANT: begin
        endGrant = !iReq[sel] || (cnt == CNT_LAST);
        if (endGrant) begin
          ptrNext = sel + 3'd1;
          cntNext = '0;
`ifdef TRANSMISSION_ARB_GUARD_EN
          stateNext = GUARD;
          validNext = 1'b0;
          grantNext = '0;
`else
          if (pickFound) begin
            selNext          = pickIdx;
            validNext        = 1'b1;
            grantNext        = '0;
            grantNext[pickIdx] = 1'b1;
          end else begin
            stateNext = IDLE;
            validNext = 1'b0;
            grantNext = '0;
          end
`endif
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: begin
        // IDLE and GUARD share the pick; selects hold when nothing is requested.
        cntNext = '0;
        if (pickFound) begin
          stateNext          = GRANT;
          selNext            = pickIdx;
          validNext          = 1'b1;
          grantNext          = '0;
          grantNext[pickIdx] = 1'b1;
        end else begin
          stateNext = IDLE;
          validNext = 1'b0;
          grantNext = '0;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
      valid <= 1'b0;
    end else begin
      state <= stateNext;
      sel   <= selNext;
      ptr   <= ptrNext;
      cnt   <= cntNext;
      grant <= grantNext;
      valid <= validNext;
    end
  end

  assign {oA, oB, oC} = sel;
  assign oGrant       = grant;
  assign oValid       = valid;
  assign oSlotCnt     = cnt;

endmodule

// File: tb/tb_transmission_arb8.sv
// Directed bench for transmission_arb8 (default build, guard disabled).
module tb_transmission_arb8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] iReq = 8'hFF;
  logic       oA, oB, oC;
  logic [7:0] oGrant;
  logic       oValid;
  logic [7:0] oSlotCnt;

  logic       rstB = 1'b1;
  logic [7:0] iReqB = 8'hFF;
  logic       oAB, oBB, oCB;
  logic [7:0] oGrantB;
  logic       oValidB;
  logic [7:0] oSlotCntB;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  transmission_arb8 #(.SLOT_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .iReq(iReq),
    .oA(oA), .oB(oB), .oC(oC),
    .oGrant(oGrant), .oValid(oValid), .oSlotCnt(oSlotCnt)
  );

  transmission_arb8 #(.SLOT_LEN(1), .CNT_W(8)) dutB (
    .clk(clk), .rst(rstB), .iReq(iReqB),
    .oA(oAB), .oB(oBB), .oC(oCB),
    .oGrant(oGrantB), .oValid(oValidB), .oSlotCnt(oSlotCntB)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       valid;
    logic [7:0] grant;
    logic [2:0] abc;
    logic [7:0] cnt;
  } vecT;

  vecT vecs[$];

  task automatic addV(input logic r, input logic [7:0] q, input logic v,
                      input logic [7:0] g, input logic [2:0] s, input logic [7:0] c);
    vecT e;
    e.rst = r; e.req = q; e.valid = v; e.grant = g; e.abc = s; e.cnt = c;
    vecs.push_back(e);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [7:0] q);
    @(negedge clk);
    rst  = r;
    iReq = q;
    @(posedge clk);
    #1;
  endtask

  task automatic chkAll(input string nm, input int idx, input logic v, input logic [7:0] g,
                        input logic [2:0] s, input logic [7:0] c);
    chk({nm, ".valid"}, idx, 32'(oValid), 32'(v));
    chk({nm, ".grant"}, idx, 32'(oGrant), 32'(g));
    chk({nm, ".abc"},   idx, 32'({oA, oB, oC}), 32'(s));
    chk({nm, ".cnt"},   idx, 32'(oSlotCnt), 32'(c));
  endtask

  initial begin
    // reset held two cycles with all requests up, then ch0 first
    addV(1, 8'hFF, 0, 8'h00, 3'd0, 0);
    addV(1, 8'hFF, 0, 8'h00, 3'd0, 0);
    addV(0, 8'hFF, 1, 8'h01, 3'd0, 0);
    // ch0 releases, nobody else: idle with selects held
    addV(0, 8'h00, 0, 8'h00, 3'd0, 0);
    // lone requester ch5 for 12 cycles, re-granted after each expiry
    for (int i = 0; i < 12; i++) addV(0, 8'h20, 1, 8'h20, 3'd5, 8'(i % 4));
    // ch0 + ch7; ch5 release coincides with its expiry
    for (int i = 0; i < 4; i++) addV(0, 8'h81, 1, 8'h80, 3'd7, 8'(i));
    for (int i = 0; i < 4; i++) addV(0, 8'h81, 1, 8'h01, 3'd0, 8'(i));
    addV(0, 8'h81, 1, 8'h80, 3'd7, 0);
    addV(0, 8'h81, 1, 8'h80, 3'd7, 1);
    // ch3 granted, drops at cnt 1; next scan starts at 4 and finds ch0
    addV(0, 8'h08, 1, 8'h08, 3'd3, 0);
    addV(0, 8'h08, 1, 8'h08, 3'd3, 1);
    addV(0, 8'h01, 1, 8'h01, 3'd0, 0);
    // ch3 raised mid-grant does not preempt ch0
    addV(0, 8'h09, 1, 8'h01, 3'd0, 1);
    addV(0, 8'h09, 1, 8'h01, 3'd0, 2);
    addV(0, 8'h09, 1, 8'h01, 3'd0, 3);
    addV(0, 8'h09, 1, 8'h08, 3'd3, 0);
    addV(0, 8'h00, 0, 8'h00, 3'd3, 0);
    addV(0, 8'h00, 0, 8'h00, 3'd3, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      chkAll("table", i, vecs[i].valid, vecs[i].grant, vecs[i].abc, vecs[i].cnt);
    end

    // reset mid-grant: ch6 at cnt 2, then rst pulse
    step(0, 8'h40); chkAll("rstMid", 0, 1, 8'h40, 3'd6, 0);
    step(0, 8'h40); chkAll("rstMid", 1, 1, 8'h40, 3'd6, 1);
    step(0, 8'h40); chkAll("rstMid", 2, 1, 8'h40, 3'd6, 2);
    step(1, 8'h40); chkAll("rstMid", 3, 0, 8'h00, 3'd0, 0);
    // ptr restarted at 0: ch3 wins over ch6 (stale ptr 4 would give ch6)
    step(0, 8'h48); chkAll("rstMid", 4, 1, 8'h08, 3'd3, 0);
    step(0, 8'h40); chkAll("rstMid", 5, 1, 8'h40, 3'd6, 0);
    step(0, 8'h40); chkAll("rstMid", 6, 1, 8'h40, 3'd6, 1);

    // SLOT_LEN = 1 with all requesting: selects advance every cycle
    @(negedge clk);
    rstB = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      chk("slot1.valid", i, 32'(oValidB), 32'd1);
      chk("slot1.abc",   i, 32'({oAB, oBB, oCB}), 32'(i % 8));
      chk("slot1.grant", i, 32'(oGrantB), 32'(1 << (i % 8)));
      chk("slot1.cnt",   i, 32'(oSlotCntB), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/transmission_arb8.md
# transmission_arb8

Round-robin time-division scheduler for the 8-way mux/demux transmission path (`transmission8`). Eight requesters share the single serial line. The block grants one channel at a time for at most `SLOT_LEN` cycles and drives the select lines S2..S0 (A, B, C) to both the 8:1 selector and the 1:8 de-selector. It also tells downstream logic which channel currently owns the line.

## Interface
Parameters:
- `SLOT_LEN`, default 4: maximum cycles per grant. Legal range is 1..2^`CNT_W`.
- `CNT_W`, default 8: width of the slot counter.

Ports:
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `iReq`, in, 8: level request, one bit per channel, bit n = channel n.
- `oA`, `oB`, `oC`, out, 1 each: select S2, S1, S0. {A,B,C} is the granted channel index, A is MSB.
- `oGrant`, out, 8: one-hot grant. All zero when no grant is active.
- `oValid`, out, 1: high while the line carries a granted channel.
- `oSlotCnt`, out, `CNT_W`: cycles elapsed in the current grant, starting at 0.

## Operation
- Registers: `state`, `sel[2:0]`, `ptr[2:0]` (round-robin start), `cnt`.
- Reset values: `state` = IDLE, `sel` = 0, `ptr` = 0, `cnt` = 0, {oA,oB,oC} = 000, `oGrant` = 0, `oValid` = 0, `oSlotCnt` = 0.
- Pick rule: the first set bit of `iReq` scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (wraps 7→0).
- IDLE:
  - If `iReq` = 0, stay in IDLE.
  - Otherwise load `sel` with the pick, `cnt` = 0, `oValid` = 1 and `oGrant` = 1<<pick, then go to GRANT.
  - In IDLE the selects hold their last value.
- GRANT:
  - Each cycle, `cnt` increments.
  - The grant ends at the edge where `iReq[sel]` = 0 (release) or `cnt` = `SLOT_LEN`-1 (expiry). Release takes precedence only for naming; the action is the same.
  - At end of grant, `ptr` ← `sel`+1 mod 8.
  - Without guard: re-pick from the new `ptr` in the same edge. The current channel, if still requesting, is naturally scanned last.
    - If the pick is found: load the new `sel`, `cnt` = 0, keep `oValid` = 1, stay in GRANT.
    - If no pick: go to IDLE with `oValid` = 0 and `oGrant` = 0.
- GUARD (only with the guard macro): one cycle with `oValid` = 0, `oGrant` = 0 and selects held. Then behave as IDLE.
- Boundaries:
  - A lone persistent requester is re-granted after expiry, and `cnt` restarts at 0.
  - Requests raised mid-grant do not preempt; they are considered at the next end of grant.
  - Release and expiry in the same cycle are a single end-of-grant event.
  - `rst` asserted in any state returns everything to the reset values at that edge, overriding all other events.

## Timing
- Grant latency: `iReq` seen in IDLE at edge N gives `oValid`/`oGrant`/selects valid after edge N. All outputs are registered.
- A full slot is exactly `SLOT_LEN` cycles of `oValid` = 1 per grant.
- Release latency: `iReq[sel]` low before edge N means the grant ends at edge N. The line changes or goes idle in cycle N+1.
- The select lines change only at end-of-grant edges, never mid-slot.

## Configuration
- `TRANSMISSION_ARB_GUARD_EN`:
  - Defined: every end of grant passes through GUARD. This gives one dead cycle (`oValid` = 0, selects stable) between any two grants, so the de-selector outputs settle before a new owner.
  - Undefined: GUARD state is absent and back-to-back grants switch in zero cycles.

## Structure
- Shared package `transmission_pkg`:
  - `NCH` = 8 and `SEL_W` = 3.
  - The state enum typedef (IDLE, GRANT, GUARD).
- Sub-module `rr_pick8`: purely combinational. Inputs `iReq[7:0]` and `ptr[2:0]`; outputs `idx[2:0]` and `found`. It is used for both the IDLE pick and the end-of-grant re-pick.

## Test plan
1. Reset: `iReq`=8'hFF, `rst` held 2 cycles → `oValid`=0, `oGrant`=0, ABC=000 throughout. First edge after `rst` falls → `oGrant`=8'h01, `oValid`=1.
2. Lone requester: `SLOT_LEN`=4, `iReq`=8'h20 held 12 cycles, no guard → ABC=101 and `oGrant`=8'h20 constant, `oValid` continuous, `oSlotCnt` 0,1,2,3 repeating.
3. Round robin: `iReq`=8'h81 held → ch0 for 4 cycles, ch7 for 4, ch0 for 4. With `TRANSMISSION_ARB_GUARD_EN`, one `oValid`=0 cycle between each grant, with ABC held.
4. Early release: ch3 granted, `iReq[3]` dropped at `oSlotCnt`=1, `iReq` then =8'h09 → next grant is ch0 (scan starts at 4), not ch3.
5. Reset mid-grant: ch6 granted at `oSlotCnt`=2, `rst` pulsed 1 cycle → next cycle all outputs are reset values. After release with `iReq`=8'h40 → ch6 re-granted with `oSlotCnt`=0 and `ptr` restarted at 0.
6. `SLOT_LEN`=1: `iReq`=8'hFF, no guard → ABC steps 000,001,…,111,000 each cycle with `oValid` constantly 1.
